// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
        logic [WORD_W-1:0]     pc;
        logic [WORD_W-1:0]     instr;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Youngest-match search over the pending write-back entries, walking from the
// tail back toward the head so the most recent write to a register wins.
module wb_lookup
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [REG_ADDR_W-1:0] ent_addr [DEPTH],
    input  logic [WORD_W-1:0]     ent_data [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]      rd_ptr,
    input  logic [PTR_W-1:0]      wr_ptr,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic [WORD_W-1:0]     data
);

    logic             done;
    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        done = 1'b0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wr_ptr - PTR_W'(k + 1);
            if (!done) begin
                if (valid[idx] && (ent_addr[idx] == addr) && (addr != REG_ZERO)) begin
                    hit  = 1'b1;
                    data = ent_data[idx];
                    done = 1'b1;
                end else if (idx == rd_ptr) begin
                    // Head reached: nothing older than it can be pending.
                    done = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue feeding the RF write port in free slots, with two
// youngest-match lookup ports for forwarding from pending writes.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_addr,
    input  logic [31:0]      in_data,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             port_free,
    output logic             rf_we,
    output logic [4:0]       rf_a3,
    output logic [31:0]      rf_wd,
    output logic [31:0]      rf_pc,
    output logic [31:0]      rf_instr,
    input  logic [4:0]       lk_addr1,
    input  logic [4:0]       lk_addr2,
    output logic             lk_hit1,
    output logic             lk_hit2,
    output logic [31:0]      lk_data1,
    output logic [31:0]      lk_data2,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    wb_entry_t               mem [DEPTH];
    logic [REG_ADDR_W-1:0]   ent_addr [DEPTH];
    logic [WORD_W-1:0]       ent_data [DEPTH];
    logic [DEPTH-1:0]        valid;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic                    push_req;
    logic                    push_en;
    logic                    pop_en;
    wb_entry_t               head;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = !full;

    // Writes to x0 complete the handshake but are dropped.
    assign push_req = in_valid && in_ready;
    assign push_en  = push_req && (in_addr != REG_ZERO);
    assign pop_en   = port_free && !empty;

    assign head     = mem[rd_ptr];
    assign rf_we    = pop_en && !reset;
    assign rf_a3    = empty ? '0 : head.addr;
    assign rf_wd    = empty ? '0 : head.data;
    assign rf_pc    = empty ? '0 : head.pc;
    assign rf_instr = empty ? '0 : head.instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr         <= wr_ptr + 1'b1;
                valid[wr_ptr]  <= 1'b1;
            end
            if (pop_en) begin
                rd_ptr         <= rd_ptr + 1'b1;
                valid[rd_ptr]  <= 1'b0;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= '{addr: in_addr, data: in_data, pc: in_pc, instr: in_instr};
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = mem[i].addr;
            ent_data[i] = mem[i].data;
        end
    end

    wb_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lookup1 (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .valid    (valid),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .addr     (lk_addr1),
        .hit      (lk_hit1),
        .data     (lk_data1)
    );

    wb_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lookup2 (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .valid    (valid),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .addr     (lk_addr2),
        .hit      (lk_hit2),
        .data     (lk_data2)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push_req && full));
    a_count_max:    assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);
    a_we_nonzero:   assert property (@(posedge clk) rf_we |-> (rf_a3 != REG_ZERO));

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, hand-written
// corner sequences, and a randomized phase checked against a queue model.
module tb_wb_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_addr;
    logic [31:0]      in_data;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             port_free;
    logic             rf_we;
    logic [4:0]       rf_a3;
    logic [31:0]      rf_wd;
    logic [31:0]      rf_pc;
    logic [31:0]      rf_instr;
    logic [4:0]       lk_addr1;
    logic [4:0]       lk_addr2;
    logic             lk_hit1;
    logic             lk_hit2;
    logic [31:0]      lk_data1;
    logic [31:0]      lk_data2;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_pc(in_pc), .in_instr(in_instr),
        .port_free(port_free),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc), .rf_instr(rf_instr),
        .lk_addr1(lk_addr1), .lk_addr2(lk_addr2),
        .lk_hit1(lk_hit1), .lk_hit2(lk_hit2), .lk_data1(lk_data1), .lk_data2(lk_data2),
        .count(count), .empty(empty), .full(full)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } mdl_t;

    mdl_t mq[$];

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
        logic        pf;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic pf,
                         input logic [4:0] l1, input logic [4:0] l2);
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        in_pc     = pc;
        in_instr  = {16'hC0DE, pc[15:0]};
        port_free = pf;
        lk_addr1  = l1;
        lk_addr2  = l2;
    endtask

    // Advance the reference queue using the inputs of the cycle about to end.
    task automatic model_step();
        bit can_push;
        can_push = (mq.size() < DEPTH);
        if (reset) begin
            mq.delete();
        end else begin
            if (port_free && mq.size() > 0) void'(mq.pop_front());
            if (in_valid && can_push && in_addr != 5'd0)
                mq.push_back('{addr: in_addr, data: in_data, pc: in_pc});
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] mlook(input logic [4:0] a);
        if (a == 5'd0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].addr == a) return {1'b1, mq[i].data};
        return 33'd0;
    endfunction

    task automatic check_model(input string tag);
        int          n;
        logic [32:0] r1;
        logic [32:0] r2;
        n  = mq.size();
        r1 = mlook(lk_addr1);
        r2 = mlook(lk_addr2);
        chk({tag, ".count"}, 32'(count), n);
        chk({tag, ".ready"}, 32'(in_ready), (n < DEPTH) ? 1 : 0);
        chk({tag, ".empty"}, 32'(empty), (n == 0) ? 1 : 0);
        chk({tag, ".we"}, 32'(rf_we), (port_free && n > 0 && !reset) ? 1 : 0);
        chk({tag, ".a3"}, 32'(rf_a3), (n > 0) ? 32'(mq[0].addr) : 0);
        chk({tag, ".wd"}, rf_wd, (n > 0) ? mq[0].data : 0);
        chk({tag, ".instr"}, rf_instr, (n > 0) ? {16'hC0DE, mq[0].pc[15:0]} : 0);
        chk({tag, ".hit1"}, 32'(lk_hit1), 32'(r1[32]));
        chk({tag, ".d1"}, lk_data1, r1[31:0]);
        chk({tag, ".hit2"}, 32'(lk_hit2), 32'(r2[32]));
        chk({tag, ".d2"}, lk_data2, r2[31:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //         v  a   d         pc        pf l1 l2  we a3 wd        pc        cnt rdy h1 d1       h2
        tbl[0]  = '{1, 3, 'h1234,   'h3000,   1, 3, 0,  0, 0, 0,        0,        0,  1,  0, 0,       0};
        tbl[1]  = '{0, 0, 0,        0,        1, 3, 0,  1, 3, 'h1234,   'h3000,   1,  1,  1, 'h1234,  0};
        tbl[2]  = '{0, 0, 0,        0,        1, 3, 0,  0, 0, 0,        0,        0,  1,  0, 0,       0};
        tbl[3]  = '{1, 5, 'h50,     'h5000,   0, 0, 0,  0, 0, 0,        0,        0,  1,  0, 0,       0};
        tbl[4]  = '{1, 6, 'h60,     'h6000,   0, 5, 0,  0, 5, 'h50,     'h5000,   1,  1,  1, 'h50,    0};
        tbl[5]  = '{1, 7, 'h70,     'h7000,   0, 0, 0,  0, 5, 'h50,     'h5000,   2,  1,  0, 0,       0};
        tbl[6]  = '{1, 8, 'h80,     'h8000,   0, 0, 0,  0, 5, 'h50,     'h5000,   3,  1,  0, 0,       0};
        tbl[7]  = '{0, 0, 0,        0,        0, 8, 0,  0, 5, 'h50,     'h5000,   4,  0,  1, 'h80,    0};
        tbl[8]  = '{0, 0, 0,        0,        1, 0, 0,  1, 5, 'h50,     'h5000,   4,  0,  0, 0,       0};
        tbl[9]  = '{0, 0, 0,        0,        1, 0, 0,  1, 6, 'h60,     'h6000,   3,  1,  0, 0,       0};
        tbl[10] = '{0, 0, 0,        0,        1, 0, 0,  1, 7, 'h70,     'h7000,   2,  1,  0, 0,       0};
        tbl[11] = '{0, 0, 0,        0,        1, 0, 0,  1, 8, 'h80,     'h8000,   1,  1,  0, 0,       0};
        tbl[12] = '{0, 0, 0,        0,        0, 0, 0,  0, 0, 0,        0,        0,  1,  0, 0,       0};
        tbl[13] = '{1, 9, 'hA,      'h9000,   0, 0, 0,  0, 0, 0,        0,        0,  1,  0, 0,       0};
        tbl[14] = '{1, 9, 'hB,      'h9004,   0, 9, 0,  0, 9, 'hA,      'h9000,   1,  1,  1, 'hA,     0};
        tbl[15] = '{0, 0, 0,        0,        0, 9, 0,  0, 9, 'hA,      'h9000,   2,  1,  1, 'hB,     0};
        tbl[16] = '{0, 0, 0,        0,        1, 9, 9,  1, 9, 'hA,      'h9000,   2,  1,  1, 'hB,     1};
        tbl[17] = '{0, 0, 0,        0,        1, 9, 0,  1, 9, 'hB,      'h9004,   1,  1,  1, 'hB,     0};
        tbl[18] = '{0, 0, 0,        0,        1, 9, 0,  0, 0, 0,        0,        0,  1,  0, 0,       0};
        tbl[19] = '{1, 0, 'hDEAD,   'hBEEF,   1, 0, 0,  0, 0, 0,        0,        0,  1,  0, 0,       0};
        tbl[20] = '{0, 0, 0,        0,        1, 0, 0,  0, 0, 0,        0,        0,  1,  0, 0,       0};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 3, 3);
        @(negedge clk);
        chk("rst.we", 32'(rf_we), 0);
        chk("rst.ready", 32'(in_ready), 1);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.count", 32'(count), 0);
        chk("rst.hit1", 32'(lk_hit1), 0);
        chk("rst.hit2", 32'(lk_hit2), 0);
        chk("rst.d1", lk_data1, 0);
        chk("rst.a3", 32'(rf_a3), 0);
        chk("rst.wd", rf_wd, 0);
        chk("rst.pc", rf_pc, 0);
        chk("rst.instr", rf_instr, 0);
        tick();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].pc, tbl[i].pf, tbl[i].l1, tbl[i].l2);
            @(negedge clk);
            chk($sformatf("v%0d.we", i), 32'(rf_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d.a3", i), 32'(rf_a3), 32'(tbl[i].e_a3));
            chk($sformatf("v%0d.wd", i), rf_wd, tbl[i].e_wd);
            chk($sformatf("v%0d.pc", i), rf_pc, tbl[i].e_pc);
            chk($sformatf("v%0d.instr", i), rf_instr,
                (tbl[i].e_pc == 0) ? 32'd0 : {16'hC0DE, tbl[i].e_pc[15:0]});
            chk($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d.ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d.full", i), 32'(full), (tbl[i].e_cnt == 3'd4) ? 1 : 0);
            chk($sformatf("v%0d.hit1", i), 32'(lk_hit1), 32'(tbl[i].e_h1));
            chk($sformatf("v%0d.d1", i), lk_data1, tbl[i].e_d1);
            chk($sformatf("v%0d.hit2", i), 32'(lk_hit2), 32'(tbl[i].e_h2));
            tick();
        end

        // Full queue, port free, producer waiting: pop first, push next cycle.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(i), 32'h100 + i, 32'h1000 + i, 0, 0, 0);
            tick();
        end
        drive(1, 10, 32'h1AA, 32'h10AA, 1, 10, 0);
        @(negedge clk);
        chk("fp.ready0", 32'(in_ready), 0);
        chk("fp.count4", 32'(count), 4);
        chk("fp.we", 32'(rf_we), 1);
        chk("fp.a3_1", 32'(rf_a3), 1);
        chk("fp.hit_none", 32'(lk_hit1), 0);
        tick();
        @(negedge clk);
        chk("fp.ready1", 32'(in_ready), 1);
        chk("fp.count3a", 32'(count), 3);
        chk("fp.a3_2", 32'(rf_a3), 2);
        tick();
        drive(0, 0, 0, 0, 0, 10, 0);
        @(negedge clk);
        chk("fp.count3b", 32'(count), 3);
        chk("fp.hit10", 32'(lk_hit1), 1);
        chk("fp.d10", lk_data1, 32'h1AA);
        tick();
        drive(0, 0, 0, 0, 1, 10, 4);
        for (int c = 0; c < 8 && mq.size() > 0; c++) begin
            @(negedge clk);
            check_model($sformatf("drain%0d", c));
            tick();
        end
        @(negedge clk);
        chk("fp.drained", 32'(empty), 1);
        chk("fp.sb_empty", 32'(mq.size()), 0);

        // Reset with three writes pending.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(11 + i), 32'h200 + i, 32'h2000 + i, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 11, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mr.count3", 32'(count), 3);
        chk("mr.we_in_reset", 32'(rf_we), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mr.count0", 32'(count), 0);
        chk("mr.we0", 32'(rf_we), 0);
        chk("mr.hit0", 32'(lk_hit1), 0);
        tick();
        drive(1, 2, 32'h22, 32'h2222, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 2, 0);
        @(negedge clk);
        chk("mr.we_post", 32'(rf_we), 1);
        chk("mr.a3_post", 32'(rf_a3), 2);
        chk("mr.wd_post", rf_wd, 32'h22);
        tick();
        @(negedge clk);
        chk("mr.empty_post", 32'(empty), 1);
        tick();

        // Randomized traffic against the reference queue.
        for (int c = 0; c < 300; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  $urandom, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            @(negedge clk);
            check_model($sformatf("rnd%0d", c));
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back queue that sources the register file's write port (WE, A3, WD, PC, Instr).
- Producers that cannot write back in their own slot, such as a multi-cycle mul/div unit or a late load, push writes into the queue.
- The queue drains one write per cycle, only in cycles the main pipeline leaves the RF write port free.
- It also serves youngest-match lookups, so the forwarding logic can bypass writes still waiting in the queue.

Parameters:
- DEPTH, 4: number of entries; a power of two, 2..16.
- PTR_W, $clog2(DEPTH): pointer width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears the queue.
- in_valid  in  1  producer has a write.
- in_ready  out  1  queue can accept; equals !full.
- in_addr  in  5  destination register.
- in_data  in  32  write data.
- in_pc  in  32  PC of the producing instruction.
- in_instr  in  32  producing instruction word.
- port_free  in  1  pipeline is not using the RF write port this cycle.
- rf_we  out  1  write enable to RF.
- rf_a3  out  5  RF write address.
- rf_wd  out  32  RF write data.
- rf_pc  out  32  PC forwarded to the RF trace.
- rf_instr  out  32  instruction forwarded to the RF trace.
- lk_addr1  in  5  lookup address, port 1.
- lk_addr2  in  5  lookup address, port 2.
- lk_hit1  out  1  pending write to lk_addr1 exists.
- lk_hit2  out  1  pending write to lk_addr2 exists.
- lk_data1  out  32  data of the youngest matching entry, port 1.
- lk_data2  out  32  data of the youngest matching entry, port 2.
- count  out  PTR_W+1  number of occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Storage: circular buffer with head (rd_ptr), tail (wr_ptr), per-entry valid bit and fields {addr, data, pc, instr}.
- Reset (synchronous): rd_ptr=wr_ptr=0, count=0, all valid bits 0. Resulting outputs:
  - rf_we=0, in_ready=1, empty=1, full=0.
  - lk_hit*=0, lk_data*=0.
  - rf_a3, rf_wd, rf_pc, rf_instr = 0.
- Reset mid-operation discards every pending entry. No RF write is issued in the reset cycle.
- Push: happens at the edge when in_valid && in_ready.
  - in_addr==0: the write is accepted (handshake completes) but not stored; count is unchanged.
- Pop: happens at the edge when port_free && !empty.
- Drain outputs are combinational from the head entry:
  - rf_we = port_free && !empty.
  - rf_a3, rf_wd, rf_pc, rf_instr = head fields when !empty, else 0.
- Latency: an entry pushed at edge N can first appear on rf_* in the cycle after edge N. There is no input-to-output bypass in the same cycle.
- in_ready = !full and does not depend on a simultaneous pop.
- Simultaneous push and pop: both take effect and count is unchanged.
- Pointers wrap modulo DEPTH.
- Lookup (combinational):
  - Compare lk_addrN against all valid entries.
  - On a hit, return the youngest match, i.e. the one nearest the tail.
  - lk_addrN==0 never hits.
  - The in_* write presented in the same cycle is not visible to lookup.
  - An entry being popped in this cycle still hits in this cycle.
  - When there is no hit, lk_dataN=0.
- Ordering: entries drain strictly FIFO. Two writes to the same register reach the RF in push order.
- port_free held low: the queue holds its contents; once full, in_ready=0. The producer must hold in_* stable while in_valid && !in_ready.
- Protocol assertions:
  - No push when full.
  - count never exceeds DEPTH.
  - rf_we implies rf_a3!=0.

Decomposition:
- Package wb_pkg:
  - REG_ADDR_W=5, WORD_W=32.
  - wb_entry_t struct {addr, data, pc, instr}.
  - Zero-register constant REG_ZERO=5'd0.
- Sub-module wb_lookup: priority youngest-match search over the entry array given rd_ptr and wr_ptr. It is instantiated twice, once per lookup port.
- Pointer and count logic stays in wb_queue.

Test Plan:
- Reset, then push {addr=3, data=32'h1234, pc=32'h3000} with port_free=1.
  - Next cycle: rf_we=1, rf_a3=3, rf_wd=32'h1234, rf_pc=32'h3000.
  - Following cycle: empty=1, rf_we=0.
- port_free=0, push 4 writes to addr 5,6,7,8.
  - After the 4th push: full=1, in_ready=0, count=4.
  - Raise port_free: entries drain in order 5,6,7,8 on consecutive cycles.
- Push addr=9 data=32'hA, then addr=9 data=32'hB, with port_free=0.
  - lk_addr1=9 gives lk_hit1=1, lk_data1=32'hB.
  - lk_addr2=0 gives lk_hit2=0.
- Push with in_addr=0.
  - in_ready stays 1, count stays 0, rf_we never asserts.
- Full queue with port_free=1 and in_valid=1.
  - Pop happens, no push (in_ready=0), count goes 4→3.
  - Next cycle the push is accepted and count stays 3.
- Three entries pending, assert reset for one cycle.
  - count=0, rf_we=0, lk_hit1=0 in the next cycle.
  - A subsequent push to addr=2 drains normally.
